// File: rtl/pmem_adaptor_pkg.sv
// Shared types and constants for the L2-to-physical-memory burst adaptor.
// Holds the FSM state encoding, default line/beat widths and the watchdog stall limit.
package pmem_adaptor_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam int         LINE_W_DEF  = 256;
  localparam int         BURST_W_DEF = 64;
  localparam logic [7:0] WDT_LIMIT   = 8'd255;

endpackage

// File: rtl/pmem_wdt.sv
// Burst stall watchdog: counts busy cycles without a beat ack; fires as the count reaches WDT_LIMIT.
// Latency: err_o rises one cycle after expired; expired is combinational; no backpressure of its own.
module pmem_wdt
  import pmem_adaptor_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic busy,
  input  logic resp_i,
  output logic expired,
  output logic err_o
);

  logic [7:0] cnt_q;

  // Fires on the stalled cycle that carries the count to WDT_LIMIT.
  assign expired = busy && !resp_i && (cnt_q == WDT_LIMIT - 8'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_o <= 1'b0;
    end else begin
      if (!busy || resp_i) begin
        cnt_q <= '0;
      end else if (cnt_q != WDT_LIMIT) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (expired) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pmem_burst_adaptor.sv
// Splits L2 line reads/writes into BEATS memory bursts; resp_o pulses BEATS+1 cycles after a zero-wait request.
// Memory stalls by withholding resp_i; optional watchdog (PMEM_ADAPTOR_WDT_EN) aborts stuck bursts with err_o.
module pmem_burst_adaptor
  import pmem_adaptor_pkg::*;
#(
  parameter int LINE_W  = LINE_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
`ifdef PMEM_ADAPTOR_WDT_EN
  ,
  output logic               err_o
`endif
);

  localparam int          BEATS     = LINE_W / BURST_W;
  localparam int          KW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [KW-1:0] LAST    = KW'(BEATS - 1);
  localparam logic [31:0] ADDR_MASK = ~(32'(LINE_W / 8) - 32'd1);

  state_t              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [LINE_W-1:0]   wr_line_q;
  logic [31:0]         addr_q;
  logic                take_wr, take_rd, rd_beat, wdt_fire;

`ifdef PMEM_ADAPTOR_WDT_EN
  pmem_wdt u_wdt (
    .clk     (clk),
    .rst     (rst),
    .busy    ((state_q == RD_BURST) || (state_q == WR_BURST)),
    .resp_i  (resp_i),
    .expired (wdt_fire),
    .err_o   (err_o)
  );
`else
  assign wdt_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    take_wr = 1'b0;
    take_rd = 1'b0;
    rd_beat = 1'b0;
    read_o  = 1'b0;
    write_o = 1'b0;
    resp_o  = 1'b0;
    burst_o = '0;
    case (state_q)
      IDLE: begin
        if (write_i) begin
          take_wr = 1'b1;
          k_d     = '0;
          state_d = WR_BURST;
        end else if (read_i) begin
          take_rd = 1'b1;
          k_d     = '0;
          state_d = RD_BURST;
        end
      end
      RD_BURST: begin
        read_o = 1'b1;
        if (resp_i) begin
          rd_beat = 1'b1;
          if (k_q == LAST) begin
            state_d = DONE;
            k_d     = '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      WR_BURST: begin
        write_o = 1'b1;
        burst_o = wr_line_q[k_q*BURST_W +: BURST_W];
        if (resp_i) begin
          if (k_q == LAST) begin
            state_d = DONE;
            k_d     = '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      DONE: begin
        resp_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Watchdog abort finishes the line with whatever beats arrived.
    if (wdt_fire) begin
      state_d = DONE;
      k_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      line_o    <= '0;
      wr_line_q <= '0;
    end else begin
      if (take_wr) begin
        wr_line_q <= line_i;
        addr_q    <= address_i & ADDR_MASK;
      end else if (take_rd) begin
        addr_q    <= address_i & ADDR_MASK;
      end
      if (rd_beat) begin
        line_o[k_q*BURST_W +: BURST_W] <= burst_i;
      end
    end
  end

  assign address_o = addr_q;

endmodule

// File: tb/tb_pmem_burst_adaptor.sv
// Bench for pmem_burst_adaptor: table of line transactions with per-beat stall gaps plus hand sequences.
// Completed lines are checked against a scoreboard queue filled when each request is driven.
module tb_pmem_burst_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o;
  logic [63:0]  burst_i, burst_o;
  logic         read_o, write_o, resp_i;
`ifdef PMEM_ADAPTOR_WDT_EN
  logic         err_o;
`endif

  pmem_burst_adaptor #(.LINE_W(256), .BURST_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
`ifdef PMEM_ADAPTOR_WDT_EN
    ,
    .err_o     (err_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         wr;
    logic         rd;
    logic [31:0]  addr;
    logic [255:0] data;
    logic [3:0][7:0] gaps;
    int           lat;
    logic [31:0]  exp_addr;
  } vec_t;

  typedef struct {
    logic [31:0]  addr;
    logic [255:0] line;
    logic         chk_line;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   resp_seen = 0;
  int   pushed = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vt[5];

  localparam logic [63:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] slot(input logic [255:0] d, input int b);
    return d[b*64 +: 64];
  endfunction

  task automatic push_exp(input logic [31:0] a, input logic [255:0] l, input logic cl);
    exp_t e;
    e.addr = a;
    e.line = l;
    e.chk_line = cl;
    sb_q.push_back(e);
    pushed++;
  endtask

  always @(negedge clk) begin
    if (!rst && resp_o) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_resp_o", 1'b1, 1'b0);
      end else begin
        mon_e = sb_q.pop_front();
        resp_seen++;
        chk("resp_address_o", address_o, mon_e.addr);
        if (mon_e.chk_line) chk("resp_line_o", line_o, mon_e.line);
      end
    end
  end

  task automatic run_vec(input int id, input vec_t v);
    int beats = 0;
    int stall = 0;
    int c = 1;
    @(posedge clk); #1;
    write_i   = v.wr;
    read_i    = v.rd;
    address_i = v.addr;
    line_i    = v.wr ? v.data : ~v.data;
    push_exp(v.exp_addr, v.data, !v.wr);
    @(posedge clk); #1;
    line_i = ~v.data;
    while (beats < 4 && c < 300) begin
      if (stall < int'(v.gaps[beats])) begin
        resp_i  = 1'b0;
        burst_i = JUNK;
      end else begin
        resp_i  = 1'b1;
        burst_i = slot(v.data, beats);
      end
      @(negedge clk);
      chk($sformatf("v%0d_read_o", id), read_o, v.rd && !v.wr);
      chk($sformatf("v%0d_write_o", id), write_o, v.wr);
      chk($sformatf("v%0d_address_o", id), address_o, v.exp_addr);
      if (v.wr && resp_i) chk($sformatf("v%0d_burst_o_b%0d", id, beats), burst_o, slot(v.data, beats));
      if (resp_i) begin
        beats++;
        stall = 0;
      end else begin
        stall++;
      end
      @(posedge clk); #1;
      c++;
    end
    if (beats < 4) chk($sformatf("v%0d_burst_timeout", id), beats, 4);
    resp_i  = 1'b1;
    burst_i = JUNK;
    @(negedge clk);
    chk($sformatf("v%0d_resp_o", id), resp_o, 1'b1);
    chk($sformatf("v%0d_latency", id), c, v.lat);
    chk($sformatf("v%0d_done_rw_o", id), read_o | write_o, 1'b0);
    @(posedge clk); #1;
    read_i  = 1'b0;
    write_i = 1'b0;
    resp_i  = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_idle_resp_o", id), resp_o, 1'b0);
    chk($sformatf("v%0d_idle_rw_o", id), read_o | write_o, 1'b0);
    if (!v.wr) chk($sformatf("v%0d_line_stable", id), line_o, v.data);
  endtask

  initial begin
    logic [255:0] d1, d2;
    int c;
    logic got;

    rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    line_i = '0; address_i = '0; burst_i = '0;

    vt[0] = '{wr:1'b0, rd:1'b1, addr:32'h1234_5678,
              data:{64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
              gaps:{8'd0, 8'd0, 8'd0, 8'd0}, lat:5, exp_addr:32'h1234_5660};
    vt[1] = '{wr:1'b1, rd:1'b0, addr:32'hABCD_EF3F,
              data:{64'hDEAD_0303_0303_0303, 64'h0202_0202_0202_0202,
                    64'h0101_0101_0101_0101, 64'h0000_0000_0000_BEEF},
              gaps:{8'd2, 8'd0, 8'd2, 8'd1}, lat:10, exp_addr:32'hABCD_EF20};
    vt[2] = '{wr:1'b1, rd:1'b1, addr:32'hFFFF_FFFF,
              data:{64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
                    64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0},
              gaps:{8'd0, 8'd0, 8'd0, 8'd0}, lat:5, exp_addr:32'hFFFF_FFE0};
    vt[3] = '{wr:1'b0, rd:1'b1, addr:32'h0000_001F,
              data:{64'hFEDC_BA98_7654_3210, 64'h0F1E_2D3C_4B5A_6978,
                    64'h8877_6655_4433_2211, 64'hCAFE_F00D_1357_9BDF},
              gaps:{8'd0, 8'd1, 8'd0, 8'd3}, lat:9, exp_addr:32'h0000_0000};
    vt[4] = '{wr:1'b1, rd:1'b0, addr:32'h8000_0020,
              data:{64'h5A5A_0000_FFFF_1234, 64'h0123_4567_89AB_CDEF,
                    64'hFFFF_FFFF_0000_0001, 64'h7777_8888_9999_AAAA},
              gaps:{8'd0, 8'd0, 8'd0, 8'd0}, lat:5, exp_addr:32'h8000_0020};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_read_o", read_o, 1'b0);
    chk("rst_write_o", write_o, 1'b0);
    chk("rst_resp_o", resp_o, 1'b0);
    chk("rst_line_o", line_o, '0);
    chk("rst_burst_o", burst_o, '0);
    chk("rst_address_o", address_o, '0);
`ifdef PMEM_ADAPTOR_WDT_EN
    chk("rst_err_o", err_o, 1'b0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    // A stray ack while idle must not start or advance anything.
    resp_i = 1'b1;
    @(negedge clk);
    chk("idle_resp_i_read_o", read_o | write_o | resp_o, 1'b0);
    @(posedge clk); #1;
    resp_i = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(i, vt[i]);

    // Reset during beat 2 of a read aborts it silently.
    @(posedge clk); #1;
    read_i = 1'b1;
    address_i = 32'h5555_5555;
    for (int b = 0; b < 2; b++) begin
      @(posedge clk); #1;
      resp_i = 1'b1;
      burst_i = 64'h9999_0000_0000_0000 | 64'(b);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    burst_i = 64'h9999_0000_0000_0002;
    @(posedge clk); #1;
    rst = 1'b0; read_i = 1'b0; resp_i = 1'b0;
    @(negedge clk);
    chk("abort_read_o", read_o, 1'b0);
    chk("abort_resp_o", resp_o, 1'b0);
    chk("abort_line_o", line_o, '0);
    chk("abort_address_o", address_o, '0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_resp_o", resp_o, 1'b0);
    end
    run_vec(10, vt[0]);

    // read_i held through DONE: one response, re-accept only from IDLE.
    d1 = {64'h0D0D_0D0D_0000_0004, 64'h0C0C_0C0C_0000_0003, 64'h0B0B_0B0B_0000_0002, 64'h0A0A_0A0A_0000_0001};
    d2 = ~d1;
    @(posedge clk); #1;
    read_i = 1'b1;
    address_i = 32'h0000_0A47;
    push_exp(32'h0000_0A40, d1, 1'b1);
    for (int b = 0; b < 4; b++) begin
      @(posedge clk); #1;
      resp_i = 1'b1;
      burst_i = slot(d1, b);
    end
    @(posedge clk); #1;
    resp_i = 1'b0;
    @(negedge clk);
    chk("hold_done_resp_o", resp_o, 1'b1);
    @(posedge clk); #1;
    push_exp(32'h0000_0A40, d2, 1'b1);
    @(negedge clk);
    chk("hold_idle_read_o", read_o, 1'b0);
    chk("hold_idle_resp_o", resp_o, 1'b0);
    for (int b = 0; b < 4; b++) begin
      @(posedge clk); #1;
      resp_i = 1'b1;
      burst_i = slot(d2, b);
      @(negedge clk);
      chk("hold_reaccept_read_o", read_o, 1'b1);
    end
    @(posedge clk); #1;
    resp_i = 1'b0;
    read_i = 1'b0;
    @(negedge clk);
    chk("hold_second_resp_o", resp_o, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_end_read_o", read_o, 1'b0);
    chk("hold_end_resp_o", resp_o, 1'b0);

`ifdef PMEM_ADAPTOR_WDT_EN
    // Memory never acknowledges: watchdog forces DONE after 255 stalled cycles.
    @(posedge clk); #1;
    read_i = 1'b1;
    address_i = 32'h0000_0100;
    push_exp(32'h0000_0100, '0, 1'b0);
    c = 0;
    got = 1'b0;
    while (c < 400 && !got) begin
      @(posedge clk); #1;
      c++;
      @(negedge clk);
      if (resp_o) got = 1'b1;
    end
    chk("wdt_resp_cycle", c, 256);
    chk("wdt_err_o", err_o, 1'b1);
    @(posedge clk); #1;
    read_i = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("wdt_err_sticky", err_o, 1'b1);
    chk("wdt_idle_read_o", read_o, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("wdt_err_cleared", err_o, 1'b0);
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    chk("resp_count", resp_seen, pushed);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pmem_burst_adaptor.md
PMEM_BURST_ADAPTOR -- requirements
Module: pmem_burst_adaptor

Interface
REQ-001 SHALL take parameter LINE_W, default 256, cache line width in bits.
REQ-002 SHALL take parameter BURST_W, default 64, memory beat width in bits; BEATS = LINE_W/BURST_W (4 at defaults).
REQ-003 clk  input  1  clock, all state updated on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 line_i  input  LINE_W  write-back line from L2 controller.
REQ-006 line_o  output  LINE_W  assembled fill line to L2 controller.
REQ-007 address_i  input  32  line request address from L2 controller.
REQ-008 read_i / write_i  input  1 each  line read / write request, held until resp_o.
REQ-009 resp_o  output  1  one-cycle line-done pulse to L2 controller.
REQ-010 burst_i  input  BURST_W  read beat from physical memory.
REQ-011 burst_o  output  BURST_W  write beat to physical memory.
REQ-012 address_o  output  32  line-aligned memory address.
REQ-013 read_o / write_o  output  1 each  memory burst read / write request.
REQ-014 resp_i  input  1  memory beat acknowledge, one per beat.

Function
REQ-015 FSM states: IDLE, RD_BURST, WR_BURST, DONE.
REQ-016 IDLE: write_i=1 -> latch line_i, address, go WR_BURST; else read_i=1 -> latch address, go RD_BURST; write_i has priority if both high.
REQ-017 Latched address SHALL have bits [log2(LINE_W/8)-1:0] forced to 0; address_o SHALL drive the latched value in every state.
REQ-018 RD_BURST: read_o=1; each cycle with resp_i=1 stores burst_i into beat slot k (slot 0 = bits [BURST_W-1:0]), k increments; gaps with resp_i=0 hold k and contents.
REQ-019 WR_BURST: write_o=1; burst_o = latched line slot k; k advances on resp_i=1.
REQ-020 Beat counter width ceil(log2(BEATS)); on the resp_i of beat BEATS-1 the FSM SHALL go DONE and clear k (no wrap to a 5th beat).
REQ-021 read_o/write_o SHALL deassert in the cycle after the last beat's resp_i.
REQ-022 DONE: resp_o=1 for exactly one cycle, line_o holds the assembled line, then IDLE unconditionally.
REQ-023 Requests seen in the DONE cycle SHALL be ignored; a new request is accepted only in IDLE (minimum two idle-to-idle gap: DONE + IDLE sample).
REQ-024 line_o SHALL remain stable from DONE until the next RD_BURST beat 0 capture.
REQ-025 resp_i in IDLE or DONE SHALL be ignored.
REQ-026 Latency with zero-wait memory: request sampled cycle 0, read_o/write_o high cycles 1..BEATS, resp_o cycle BEATS+1.

Reset
REQ-027 rst=1 SHALL force IDLE, k=0, read_o=0, write_o=0, resp_o=0, line_o=0, burst_o=0, address_o=0 at the next edge.
REQ-028 rst asserted mid-burst SHALL abort the burst without resp_o; partial line data discarded.

Configuration
REQ-029 Macro PMEM_ADAPTOR_WDT_EN: when defined, adds output err_o (1 bit) and an 8-bit wait counter cleared on every resp_i and on burst entry, incremented each RD_BURST/WR_BURST cycle without resp_i.
REQ-030 With PMEM_ADAPTOR_WDT_EN, counter reaching 255 SHALL set err_o sticky (cleared only by rst) and force DONE (resp_o pulse, partial data).
REQ-031 Without PMEM_ADAPTOR_WDT_EN, no err_o port, no counter, bursts wait indefinitely.

Structure
REQ-032 Package pmem_adaptor_pkg SHALL hold the state enum, default LINE_W/BURST_W constants and WDT_LIMIT=255.
REQ-033 Optional sub-module pmem_wdt holds the watchdog counter, instantiated only under PMEM_ADAPTOR_WDT_EN; datapath and FSM stay in one module.

Verification
REQ-034 Read, zero-wait: address_i=0x1234_5678, beats 0x11..,0x22..,0x33..,0x44.. -> address_o=0x1234_5660, line_o={0x44..,0x33..,0x22..,0x11..}, resp_o cycle 5.
REQ-035 Write with gaps: line_i=256'hDEAD...BEEF, resp_i high cycles 2,5,6,9 -> burst_o slots 0..3 in order, write_o low cycle 10, resp_o cycle 10.
REQ-036 read_i=write_i=1 in IDLE -> write burst only, read_o never high.
REQ-037 rst at beat 2 of read -> read_o=0 next cycle, no resp_o, next read completes normally.
REQ-038 WDT_EN, resp_i held 0 after read start -> err_o=1 and resp_o pulse after 255 stalled cycles; err_o stays 1 until rst.
REQ-039 read_i held high through DONE -> exactly one resp_o per request, re-accept only from IDLE.
